// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle for seq_bit_serializer.
// master = word source / stream consumer side, slave = the serializer itself.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_start;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  word_start,
    input  busy,
    input  words_sent
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output ser_out,
    output ser_valid,
    output word_start,
    output busy,
    output words_sent
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detector: accepts words over
// valid/ready and emits them one bit per clock, back-to-back without bubbles.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_bit_serializer_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_word_start;
  logic [CNT_W-1:0] r_words_sent;

  logic             w_load_ready;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shreg_shifted;

  // Ready in IDLE and in the last-bit slot so a waiting word reloads gap-free.
  assign w_load_ready = !rst && ((r_state == S_IDLE) ||
                                 ((r_state == S_SHIFT) && (r_cnt == '0)));
  assign w_accept     = bus.load_valid && w_load_ready;

  always_comb begin
    w_first_bit     = 1'b0;
    w_next_bit      = 1'b0;
    w_shreg_shifted = '0;
    if (MSB_FIRST) begin
      w_first_bit     = bus.load_data[WIDTH-1];
      w_next_bit      = r_shreg[WIDTH-2];
      w_shreg_shifted = r_shreg << 1;
    end else begin
      w_first_bit     = bus.load_data[0];
      w_next_bit      = r_shreg[1];
      w_shreg_shifted = r_shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_ser_out    <= IDLE_BIT;
      r_ser_valid  <= 1'b0;
      r_word_start <= 1'b0;
      r_words_sent <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_SHIFT;
            r_shreg      <= bus.load_data;
            r_cnt        <= CW'(WIDTH - 1);
            r_ser_out    <= w_first_bit;
            r_ser_valid  <= 1'b1;
            r_word_start <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_shreg      <= w_shreg_shifted;
            r_cnt        <= r_cnt - CW'(1);
            r_ser_out    <= w_next_bit;
            r_word_start <= 1'b0;
          end else begin
            // Last-bit cycle completes the word regardless of a reload.
            r_words_sent <= r_words_sent + CNT_W'(1);
            if (w_accept) begin
              r_shreg      <= bus.load_data;
              r_cnt        <= CW'(WIDTH - 1);
              r_ser_out    <= w_first_bit;
              r_ser_valid  <= 1'b1;
              r_word_start <= 1'b1;
            end else begin
              r_state      <= S_IDLE;
              r_ser_out    <= IDLE_BIT;
              r_ser_valid  <= 1'b0;
              r_word_start <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_ser_out    <= IDLE_BIT;
          r_ser_valid  <= 1'b0;
          r_word_start <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.word_start = r_word_start;
  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.words_sent = r_words_sent;

endmodule
